// File: rtl/full_subtractor.sv
// Registered WIDTH-bit full subtractor: D = a - b - Bin, borrow-out Bout, one-cycle latency.
// Define FULL_SUBTRACTOR_OVF_EN to add a registered two's-complement overflow flag (ovf).
module full_subtractor #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Bin,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
`ifdef FULL_SUBTRACTOR_OVF_EN
    output logic             ovf,
`endif
    output logic             out_valid
);

    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] diff;

    // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
    always_comb begin
        borrow    = '0;
        diff      = '0;
        borrow[0] = Bin;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i]       = a[i] ^ b[i] ^ borrow[i];
            borrow[i+1]   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
        end
    end

`ifdef FULL_SUBTRACTOR_OVF_EN
    logic ovf_next;

    // Signed overflow: operand signs differ and the result sign departs from the minuend's.
    always_comb begin
        ovf_next = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    end
`endif

    // NOTE: sequential state uses non-blocking assignments; reset wins over a coincident in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            D         <= '0;
            Bout      <= 1'b0;
            out_valid <= 1'b0;
`ifdef FULL_SUBTRACTOR_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                D    <= diff;
                Bout <= borrow[WIDTH];
`ifdef FULL_SUBTRACTOR_OVF_EN
                ovf  <= ovf_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_full_subtractor.sv
// Scoreboard bench for full_subtractor: WIDTH=1 and WIDTH=8 instances against an arithmetic model.
module tb_full_subtractor;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       v1, a1, b1, bin1;
    logic       d1, bout1, ov1_valid;
    logic       v8, bin8;
    logic [7:0] a8, b8, d8;
    logic       bout8, ov8_valid;
`ifdef FULL_SUBTRACTOR_OVF_EN
    logic       ovf1, ovf8;
`endif

    exp_t q1[$];
    exp_t q8[$];
    exp_t e1, e8;
    int   total = 0;
    int   passed = 0;
    int   run8 = 0;

    full_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .Bin(bin1),
        .D(d1), .Bout(bout1),
`ifdef FULL_SUBTRACTOR_OVF_EN
        .ovf(ovf1),
`endif
        .out_valid(ov1_valid)
    );

    full_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .Bin(bin8),
        .D(d8), .Bout(bout8),
`ifdef FULL_SUBTRACTOR_OVF_EN
        .ovf(ovf8),
`endif
        .out_valid(ov8_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    // Reference: plain integer subtraction, unsigned for D/Bout, signed range test for ovf.
    function automatic exp_t model(input int w, input int a, input int b, input int bin);
        exp_t e;
        int r, sa, sb, sr;
        r    = a - b - bin;
        e.d  = 8'(r & ((1 << w) - 1));
        e.bo = (r < 0);
        sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        sr   = sa - sb - bin;
        e.ov = (sr < -(1 << (w - 1))) || (sr > (1 << (w - 1)) - 1);
        return e;
    endfunction

    task automatic cyc1(input logic v, input logic ai, input logic bi, input logic bn);
        v8 = 1'b0;
        v1 = v; a1 = ai; b1 = bi; bin1 = bn;
        if (v && !rst) q1.push_back(model(1, int'(ai), int'(bi), int'(bn)));
        @(posedge clk);
        #1;
    endtask

    task automatic cyc8(input logic v, input logic [7:0] ai, input logic [7:0] bi, input logic bn);
        v1 = 1'b0;
        v8 = v; a8 = ai; b8 = bi; bin8 = bn;
        if (v && !rst) q8.push_back(model(8, int'(ai), int'(bi), int'(bn)));
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation for every cycle a DUT presents out_valid.
    always @(negedge clk) begin
        if (ov1_valid) begin
            if (q1.size() == 0) begin
                check("spurious_valid1", 64'(ov1_valid), 64'd0);
            end else begin
                e1 = q1.pop_front();
                check("d1", 64'(d1), 64'(e1.d[0]));
                check("bout1", 64'(bout1), 64'(e1.bo));
`ifdef FULL_SUBTRACTOR_OVF_EN
                check("ovf1", 64'(ovf1), 64'(e1.ov));
`endif
            end
        end
        if (ov8_valid) begin
            run8++;
            if (q8.size() == 0) begin
                check("spurious_valid8", 64'(ov8_valid), 64'd0);
            end else begin
                e8 = q8.pop_front();
                check("d8", 64'(d8), 64'(e8.d));
                check("bout8", 64'(bout8), 64'(e8.bo));
`ifdef FULL_SUBTRACTOR_OVF_EN
                check("ovf8", 64'(ovf8), 64'(e8.ov));
`endif
            end
        end else begin
            run8 = 0;
        end
    end

    initial begin
        rst = 1'b1;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
        v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
        cyc8(1'b1, 8'hAA, 8'h11, 1'b1);
        cyc8(1'b0, 8'h00, 8'h00, 1'b0);
        check("rst_d8", 64'(d8), 64'd0);
        check("rst_bout8", 64'(bout8), 64'd0);
        check("rst_valid8", 64'(ov8_valid), 64'd0);
        check("rst_d1", 64'(d1), 64'd0);
        check("rst_valid1", 64'(ov1_valid), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            cyc1(1'b1, v[2], v[1], v[0]);
        end
        cyc1(1'b0, 1'b0, 1'b0, 1'b0);

        cyc8(1'b1, 8'h50, 8'h20, 1'b0);
        cyc8(1'b1, 8'h00, 8'hFF, 1'b1);
        cyc8(1'b1, 8'h7F, 8'h7F, 1'b1);
        cyc8(1'b1, 8'h3C, 8'h3C, 1'b0);
        cyc8(1'b1, 8'h80, 8'h01, 1'b0);
        cyc8(1'b1, 8'h10, 8'h01, 1'b0);

        cyc8(1'b1, 8'h01, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) cyc8(1'b0, 8'h00, 8'h01, 1'b1);
        check("hold_d8", 64'(d8), 64'd1);
        check("hold_bout8", 64'(bout8), 64'd0);
        check("hold_valid8", 64'(ov8_valid), 64'd0);

        rst = 1'b1;
        cyc8(1'b1, 8'h00, 8'h01, 1'b0);
        check("rstpri_d8", 64'(d8), 64'd0);
        check("rstpri_bout8", 64'(bout8), 64'd0);
        check("rstpri_valid8", 64'(ov8_valid), 64'd0);
        rst = 1'b0;
        cyc8(1'b1, 8'h05, 8'h03, 1'b1);
        cyc8(1'b0, 8'h00, 8'h00, 1'b0);

        for (int i = 0; i < 16; i++)
            cyc8(1'b1, 8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)));
        @(negedge clk);
        #1;
        check("throughput_run8", 64'(run8), 64'd16);
        cyc8(1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        #1;

        check("pending_q1", 64'(q1.size()), 64'd0);
        check("pending_q8", 64'(q8.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/full_subtractor.md
Name: full_subtractor

Overview:
- Registered full subtractor: computes D = a − b − Bin and borrow-out Bout over WIDTH bits.
- Result is captured on the clock edge after a valid input.
- Used as a leaf arithmetic cell. With WIDTH=1 it is the classic 1-bit full subtractor. Bout can chain into the Bin of a following stage.
- Internally a ripple chain of 1-bit full-subtract cells feeding an output register with a valid flag.

Parameters:
- WIDTH, 1, operand and difference width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a/b/Bin are valid this cycle; capture them.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- Bin  input  1  borrow-in.
- D  output  WIDTH  registered difference.
- Bout  output  1  registered borrow-out.
- out_valid  output  1  D/Bout were updated by the previous cycle's capture.

Behaviour:
- Arithmetic:
  - D = (a − b − Bin) mod 2^WIDTH.
  - Bout = 1 iff a < b + Bin, with the comparison taken unsigned at WIDTH+1 bits.
- Per-bit cell i (borrow chain b0 = Bin, Bout = b_WIDTH):
  - d_i = a_i ^ b_i ^ b_(i)
  - b_(i+1) = (~a_i & b_i) | (~(a_i ^ b_i) & b_(i))
- 1-bit truth table, listed as a,b,Bin -> D,Bout: 000->0,0; 001->1,1; 010->1,1; 011->0,1; 100->1,0; 101->0,0; 110->0,0; 111->1,1.
- Latency: exactly one clock. Inputs sampled at edge N with in_valid=1 appear on D/Bout after edge N, and out_valid=1 for that cycle.
- in_valid=0 at an edge: D and Bout hold their previous values; out_valid goes 0.
- Back-to-back valids: one result per cycle, no bubbles, no backpressure.
- Reset, rst=1 at a rising edge: D=0, Bout=0, out_valid=0 (plus ovf=0 when the optional feature is enabled).
  - Reset has priority over a simultaneous in_valid. That input is dropped, not captured.
- Reset mid-stream: the first capture after rst deasserts is the first valid sample at or after the first edge with rst=0.
- Boundaries:
  - a == b, Bin=0 -> D=0, Bout=0.
  - a == b, Bin=1 -> D=all ones, Bout=1.
  - a=0, b=all ones, Bin=1 -> D=0, Bout=1 (wrap-around).
- Outputs are purely registered. No combinational path from inputs to outputs.
- Unknown (X) inputs while in_valid=0 must not affect D or Bout.

Optional Feature:
- Macro FULL_SUBTRACTOR_OVF_EN.
- Defined: adds output port ovf (output, 1 bit), registered with D. Operands are treated as two's complement. ovf=1 iff the signed result a − b − Bin is not representable in WIDTH bits, i.e. a_msb != b_msb and D_msb != a_msb.
  - ovf holds when in_valid=0 and resets to 0.
- Undefined: port ovf and its logic are absent; all other behaviour is unchanged.

Test Plan:
- WIDTH=1, exhaustive: apply the 8 (a,b,Bin) combinations 000..111, in_valid=1, one per cycle. Each result appears one cycle later and matches the truth table, e.g. 011 -> D=0,Bout=1 and 100 -> D=1,Bout=0.
- WIDTH=8 arithmetic:
  - a=0x50, b=0x20, Bin=0 -> D=0x30, Bout=0.
  - a=0x00, b=0xFF, Bin=1 -> D=0x00, Bout=1.
  - a=0x7F, b=0x7F, Bin=1 -> D=0xFF, Bout=1.
- Hold: capture a=1,b=0,Bin=0 (D=1,Bout=0), then drive in_valid=0 with a=0,b=1,Bin=1 for 3 cycles. D=1 and Bout=0 are unchanged, and out_valid=0.
- Reset priority: rst=1 and in_valid=1 with a=0,b=1,Bin=0 on the same edge. After the edge D=0, Bout=0, out_valid=0. The next edge with rst=0 and in_valid=1 captures normally.
- Throughput: 16 consecutive random valid vectors (WIDTH=8). out_valid stays high for 16 cycles, starting one cycle after the first input, and every result matches the reference model.
- FULL_SUBTRACTOR_OVF_EN, WIDTH=8:
  - a=0x80, b=0x01, Bin=0 -> D=0x7F, ovf=1.
  - a=0x10, b=0x01, Bin=0 -> D=0x0F, ovf=0.
